// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the mem_access load/store sequencer: access-size
// encodings, FSM state encoding, the latched request control fields and the
// alignment rule used to reject requests before they reach data_mem.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_access_pkg;

   // Lane logic is written for four byte lanes, so the word is fixed at 32.
   localparam int unsigned WORD_W = 32;

   // Access-size encodings carried on req_size; 2'b11 is reserved.
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      MA_IDLE = 2'b00,
      MA_RD   = 2'b01,
      MA_WR   = 2'b10,
      MA_RSP  = 2'b11
   } ma_state_e;

   // Control fields of the accepted request.
   typedef struct packed {
      logic       store;
      logic [1:0] size;
      logic       uns;
   } req_ctl_t;

   // A request is rejected when its size is reserved or when it does not sit
   // on its natural boundary within the word.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] offset);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return offset[0];
         SZ_WORD: return (offset != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_data_align.sv
// -----------------------------------------------------------------------------
// mem_access_data_align
// Combinational lane logic shared by the load and store paths.
//   size       in  2  : access size (byte / half / word)
//   offset     in  2  : byte offset of the access within the word
//   uns        in  1  : 1 = zero-extend loads, 0 = sign-extend
//   old_word   in  32 : word currently held in memory (data_mem read data)
//   new_data   in  32 : store data, taken from the low bits
//   load_data  out 32 : addressed lane shifted to bit 0 and extended
//   merge_word out 32 : old_word with the addressed lane replaced by new_data
//                       (the full new_data for a word store)
// -----------------------------------------------------------------------------
module mem_access_data_align
   import mem_access_pkg::*;
(
   input  logic [1:0]        size,
   input  logic [1:0]        offset,
   input  logic              uns,
   input  logic [WORD_W-1:0] old_word,
   input  logic [WORD_W-1:0] new_data,
   output logic [WORD_W-1:0] load_data,
   output logic [WORD_W-1:0] merge_word
);

   logic [WORD_W-1:0] shifted;

   // NOTE: every signal written in an always_comb gets a default on entry so
   // that no path leaves it unassigned, which would infer a latch.
   always_comb begin
      shifted   = old_word >> {offset, 3'b000};
      load_data = old_word;
      case (size)
         SZ_BYTE: load_data = {{24{~uns & shifted[7]}},  shifted[7:0]};
         SZ_HALF: load_data = {{16{~uns & shifted[15]}}, shifted[15:0]};
         default: load_data = old_word;
      endcase
   end

   always_comb begin
      merge_word = new_data;
      case (size)
         SZ_BYTE: begin
            merge_word = old_word;
            merge_word[{offset, 3'b000} +: 8] = new_data[7:0];
         end
         SZ_HALF: begin
            // Halves are aligned, so only offset[1] picks the lane.
            merge_word = old_word;
            merge_word[{offset[1], 4'b0000} +: 16] = new_data[15:0];
         end
         default: merge_word = new_data;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
// Load/store sequencer in front of a word-wide data_mem with registered read
// data. One request is in flight at a time; sub-word stores are done as
// read-modify-write, and misaligned or reserved-size requests are answered
// with an error without any memory cycle.
//   clk, rst_n                     : clock, synchronous active-low reset
//   req_valid/req_ready            : request handshake
//   req_store, req_size,
//   req_unsigned, req_addr,
//   req_wdata                      : request fields (req_addr is a byte addr)
//   rsp_valid/rsp_ready            : response handshake
//   rsp_data, rsp_err              : load result / error flag (0 off-response)
//   mem_addr, mem_write,
//   mem_wdata, mem_rdata           : data_mem port (word address)
// -----------------------------------------------------------------------------
module mem_access
   import mem_access_pkg::*;
#(
   parameter int W  = 32,   // must equal WORD_W: lane logic assumes 4 bytes
   parameter int AW = 8     // word-address width of data_mem
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_store,
   input  logic [1:0]    req_size,
   input  logic          req_unsigned,
   input  logic [AW+1:0] req_addr,
   input  logic [W-1:0]  req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [W-1:0]  rsp_data,
   output logic          rsp_err,
   output logic [AW-1:0] mem_addr,
   output logic          mem_write,
   output logic [W-1:0]  mem_wdata,
   input  logic [W-1:0]  mem_rdata
);

   ma_state_e     state_q, state_d;
   req_ctl_t      ctl_q, ctl_d;
   logic [AW+1:0] addr_q, addr_d;
   logic [W-1:0]  wdata_q, wdata_d;
   logic          err_q, err_d;
   logic          req_ready_q, req_ready_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          wr_q, wr_d;

   logic [W-1:0]  load_data;
   logic [W-1:0]  merge_word;

   always_comb begin
      state_d = state_q;
      ctl_d   = ctl_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;

      case (state_q)
         MA_IDLE: begin
            // req_ready is 1 throughout IDLE, so req_valid here is an accept.
            if (req_valid) begin
               ctl_d   = '{store: req_store, size: req_size, uns: req_unsigned};
               addr_d  = req_addr;
               wdata_d = req_wdata;
               err_d   = is_misaligned(req_size, req_addr[1:0]);
               if (err_d)
                  state_d = MA_RSP;
               else if (!req_store)
                  state_d = MA_RD;
               else if (req_size == SZ_WORD)
                  state_d = MA_WR;
               else
                  state_d = MA_RD;   // sub-word store: read the old word first
            end
         end
         MA_RD:   state_d = ctl_q.store ? MA_WR : MA_RSP;
         MA_WR:   state_d = MA_RSP;
         MA_RSP:  if (rsp_ready) state_d = MA_IDLE;
         default: state_d = MA_IDLE;
      endcase
   end

   // Output flags are decoded from the next state so they come out of flops.
   always_comb begin
      req_ready_d = (state_d == MA_IDLE);
      rsp_valid_d = (state_d == MA_RSP);
      wr_d        = (state_d == MA_WR);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= MA_IDLE;
         ctl_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         wr_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         ctl_q       <= ctl_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         wr_q        <= wr_d;
      end
   end

   mem_access_data_align u_align (
      .size       (ctl_q.size),
      .offset     (addr_q[1:0]),
      .uns        (ctl_q.uns),
      .old_word   (mem_rdata),
      .new_data   (wdata_q),
      .load_data  (load_data),
      .merge_word (merge_word)
   );

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_valid_q & err_q;
   // mem_rdata still holds the word read in RD: the address is held and no
   // write happens between RD and the end of RSP for a load.
   assign rsp_data  = (rsp_valid_q && !err_q && !ctl_q.store) ? load_data : '0;

   assign mem_addr  = req_ready_q ? '0 : addr_q[AW+1:2];
   // The write strobe is gated by rst_n directly so that a reset arriving on
   // the WR edge suppresses the write in the same cycle.
   assign mem_write = wr_q & rst_n;
   // In WR, mem_rdata is the old word latched at the end of RD (or unused for
   // a word store, where merge_word is the store data itself).
   assign mem_wdata = wr_q ? merge_word : '0;

endmodule

// File: doc/mem_access.md
# mem_access

Load/store sequencer that sits directly upstream of `data_mem` in the memory stage. It accepts one byte, halfword or word load or store per request over a valid/ready handshake. It drives the word-wide `data_mem` port, using read-modify-write for sub-word stores, and returns one response per request with aligned, sign- or zero-extended load data. Misaligned and reserved-size requests are rejected without touching memory.

## Interface
- `W`, `` `WORD_WIDTH ``: data word width; must be 32, because lane logic assumes 4 bytes.
- `AW`, `` `ADDR_WIDTH ``: word-address width of `data_mem`.
- `clk` in 1: single clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_store` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in AW+2: byte address.
- `req_wdata` in W: store data, taken from the low bits.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_data` out W: load result; 0 for stores and for errors.
- `rsp_err` out 1: misaligned access or reserved size.
- `mem_addr` out AW: word address to `data_mem`, equal to `req_addr[AW+1:2]` of the latched request.
- `mem_write` out 1: write strobe to `data_mem`.
- `mem_wdata` out W: write data to `data_mem`.
- `mem_rdata` in W: `data_mem` read data; registered, updated only on edges where `mem_write` = 0.

## Operation
- States:
  - IDLE: `req_ready` = 1.
  - RD: memory read cycle.
  - WR: memory write cycle.
  - RSP: response held.
- On accept, latch store, size, unsigned, address and write data.
- State transitions out of IDLE on accept:
  - Error, i.e. size 11, or half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0: go to RSP with `rsp_err` = 1. No memory cycle is issued.
  - Load: go to RD.
  - Word store: go to WR.
  - Byte or half store: go to RD.
- RD goes to RSP for a load and to WR for a store.
- WR goes to RSP.
- RSP goes to IDLE on `rsp_ready`.
- `mem_addr` holds the latched word address in every state other than IDLE. It is 0 in IDLE.
- `mem_write` = 1 only in WR, and is gated by `rst_n`, so no write occurs on a reset edge.
- `mem_wdata` in WR:
  - Word store: the latched write data.
  - Sub-word store: `mem_rdata` with only the addressed byte or half lane replaced. The lane is selected by `addr[1:0]`, and `mem_rdata` is valid because it was latched at the end of RD.
  - `mem_wdata` is 0 outside WR.
- Load `rsp_data` in RSP:
  - The selected lane of `mem_rdata` is shifted to bit 0, then extended per `req_unsigned`.
  - `mem_rdata` stays stable through a stalled RSP because `mem_write` = 0 and `mem_addr` is held.
- `rsp_err`, `rsp_data` and `rsp_valid` are meaningful only in RSP, and are 0 elsewhere.
- Only one request is in flight at a time; `req_ready` = 0 outside IDLE.

## Timing
- Latency is counted from the accept cycle (c0) to the first `rsp_valid` cycle:
  - Load: 2 (RD, RSP).
  - Word store: 2 (WR, RSP).
  - Byte or half store: 3 (RD, WR, RSP).
  - Error: 1.
- Maximum throughput is one request per 3 cycles for loads and word stores, assuming `rsp_ready` is held at 1.
- `rsp_ready` low: stay in RSP with all outputs frozen.
- Response consumed and next request: a response is consumed on the edge that leaves RSP, and the next request may be accepted in the following cycle (IDLE). There is no same-cycle bypass.
- `rsp_ready` may be high before `rsp_valid`; this has no effect.
- `rst_n` low at any edge: next state IDLE and the latched request cleared to 0. Any in-flight access is dropped and no response is issued. A write scheduled for that edge is suppressed.
- Reset values: `req_ready` = 1 once in IDLE; `rsp_valid`, `rsp_err`, `rsp_data`, `mem_addr`, `mem_write` and `mem_wdata` are all 0.

## Structure
- `defines.v` gains the size encodings `` `SZ_BYTE ``, `` `SZ_HALF ``, `` `SZ_WORD `` and the state encodings `` `MA_IDLE ``, `` `MA_RD ``, `` `MA_WR ``, `` `MA_RSP ``.
- One combinational sub-module, `data_align`, covers both lane paths:
  - Load: lane extract plus extension.
  - Store: lane merge.
  - Inputs: size, offset, unsigned, old word, new data.
- FSM and request register live in `mem_access`.
- The bench instantiates `mem_access` driving a real `data_mem`.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles and release, then check `req_ready` = 1 with all other outputs 0.
- Word store then word load:
  - Stimulus: store 0xDEADBEEF to byte address 0x08, then load a word from 0x08.
  - Expect: `rsp_data` = 0xDEADBEEF, `rsp_err` = 0, store latency 2 and load latency 2.
- Byte store merge:
  - Stimulus: store the byte 0x5A to 0x09 over the existing 0xDEADBEEF.
  - Expect: 3-cycle latency, then a word load from 0x08 returns 0xDEAD5AEF.
- Sign and zero extension:
  - Stimulus: with 0xDEAD5AEF at 0x08, do a signed half load at 0x0A, an unsigned half load at 0x0A, and a signed byte load at 0x08.
  - Expect, respectively: 0xFFFFDEAD, 0x0000DEAD, 0xFFFFFFEF.
- Misalignment:
  - Stimulus: a word load at 0x0A, a half store at 0x0B, and `req_size` = 11.
  - Expect: each gives `rsp_err` = 1 and `rsp_data` = 0 with latency 1, `mem_write` never rises, and memory is unchanged.
- Stall and reset mid-operation:
  - Stall: hold `rsp_ready` = 0 for 5 cycles on a load. Expect `rsp_data` stable and `req_ready` = 0 for the duration.
  - Reset: assert `rst_n` = 0 in the WR cycle of a store. Expect no write to occur and a later load to return the old value.
